spi_cmd_ctrl: RTL and testbench

SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

---
 rtl/spi_cmd_pkg.sv | 22 ++
 rtl/spi_cmd_wdog.sv | 32 +++
 rtl/spi_cmd_ctrl.sv | 143 ++++++++++++++
 tb/tb_spi_cmd_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command controller: FSM state encoding,
// command-byte layout and the default register address width.
package spi_cmd_pkg;

    localparam int unsigned DEF_ADDR_W = 7;
    localparam int unsigned CMD_WR_BIT = 7;
    localparam logic [7:0]  ERR_BYTE   = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    // States in which a frame is actively being decoded (watchdog armed)
    function automatic logic is_frame_state(input state_t s);
        return (s == ST_CMD) || (s == ST_WRITE) || (s == ST_READ);
    endfunction

endpackage

// File: rtl/spi_cmd_wdog.sv
// Inter-byte watchdog: counts idle cycles while a frame is active and flags
// a timeout once the count reaches CYCLES-1.
module spi_cmd_wdog
    import spi_cmd_pkg::*;
#(
    parameter int unsigned CYCLES = 4096
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_active,
    input  logic i_clear,
    output logic o_timeout
);

    localparam int unsigned CNT_W = $clog2(CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (!i_active || i_clear) begin
            r_count <= '0;
        end else if (r_count != LAST) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_timeout = i_active && (r_count == LAST);

endmodule

// File: rtl/spi_cmd_ctrl.sv
// Byte-level SPI command decoder driving a simple register-file port.
// Optional inter-byte watchdog enabled by defining SPI_CMD_WDOG_EN.
module spi_cmd_ctrl
    import spi_cmd_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
`ifdef SPI_CMD_WDOG_EN
    ,
    parameter int unsigned WDOG_CYCLES = 4096
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ssel_active,
    input  logic              i_byte_done,
    input  logic [7:0]        i_byte_rx,
    output logic [7:0]        o_byte_tx,
    input  logic [7:0]        i_status,
    output logic [ADDR_W-1:0] o_reg_addr,
    output logic [7:0]        o_reg_wdata,
    output logic              o_reg_we,
    output logic              o_reg_re,
    input  logic [7:0]        i_reg_rdata,
    output logic              o_busy,
    output logic              o_frame_err
);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_byte_tx;
    logic [ADDR_W-1:0]   r_reg_addr;
    logic [7:0]          r_reg_wdata;
    logic                r_reg_we;
    logic                r_reg_re;
    logic                r_rd_pend;
    logic                r_frame_err;
    logic                w_wdog_fire;
    logic [ADDR_W-1:0]   w_addr_inc;

    assign w_addr_inc = r_addr + ADDR_W'(1);

`ifdef SPI_CMD_WDOG_EN
    logic w_timeout;

    spi_cmd_wdog #(
        .CYCLES (WDOG_CYCLES)
    ) u_wdog (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_active  (i_ssel_active && is_frame_state(r_state)),
        .i_clear   (i_byte_done),
        .o_timeout (w_timeout)
    );

    // A byte arriving in the expiry cycle counts as activity and wins
    assign w_wdog_fire = w_timeout && !i_byte_done;
`else
    assign w_wdog_fire = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_byte_tx   <= 8'h00;
            r_reg_addr  <= '0;
            r_reg_wdata <= 8'h00;
            r_reg_we    <= 1'b0;
            r_reg_re    <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_reg_we    <= 1'b0;
            r_reg_re    <= 1'b0;
            r_frame_err <= 1'b0;
            r_rd_pend   <= r_reg_re;

            if (!i_ssel_active) begin
                r_state   <= ST_IDLE;
                r_byte_tx <= i_status;
            end else if (w_wdog_fire) begin
                r_state     <= ST_ERR;
                r_byte_tx   <= ERR_BYTE;
                r_frame_err <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_byte_tx <= i_status;
                        r_state   <= ST_CMD;
                    end
                    ST_CMD: begin
                        if (i_byte_done) begin
                            r_addr <= i_byte_rx[ADDR_W-1:0];
                            if (i_byte_rx[CMD_WR_BIT]) begin
                                r_state <= ST_WRITE;
                            end else begin
                                // Prefetch the command address so the first
                                // response byte is ready for the next transfer
                                r_state    <= ST_READ;
                                r_reg_re   <= 1'b1;
                                r_reg_addr <= i_byte_rx[ADDR_W-1:0];
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (i_byte_done) begin
                            r_reg_we    <= 1'b1;
                            r_reg_addr  <= r_addr;
                            r_reg_wdata <= i_byte_rx;
                            r_addr      <= w_addr_inc;
                            r_byte_tx   <= i_byte_rx;
                        end
                    end
                    ST_READ: begin
                        if (i_byte_done) begin
                            r_addr     <= w_addr_inc;
                            r_reg_re   <= 1'b1;
                            r_reg_addr <= w_addr_inc;
                        end
                        if (r_rd_pend) begin
                            r_byte_tx <= i_reg_rdata;
                        end
                    end
                    ST_ERR: begin
                        r_byte_tx <= ERR_BYTE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_byte_tx   = r_byte_tx;
    assign o_reg_addr  = r_reg_addr;
    assign o_reg_wdata = r_reg_wdata;
    assign o_reg_we    = r_reg_we;
    assign o_reg_re    = r_reg_re;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Scoreboard bench for spi_cmd_ctrl: register strobes are checked by a monitor
// against a queue of expected accesses; byte_tx/busy are checked directly.
module tb_spi_cmd_ctrl;

    localparam logic [7:0] STATUS = 8'h5A;

    typedef struct packed {
        logic       we;
        logic [6:0] addr;
        logic [7:0] data;
    } txn_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ssel = 1'b0;
    logic       byte_done = 1'b0;
    logic [7:0] byte_rx = 8'h00;
    logic [7:0] byte_tx;
    logic [7:0] status = STATUS;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'h00;
    logic       busy;
    logic       frame_err;

    logic [7:0] mem [0:127];
    txn_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         ferr_cnt = 0;

    always #5 clk = ~clk;

    spi_cmd_ctrl #(
        .ADDR_W (7)
`ifdef SPI_CMD_WDOG_EN
        ,
        .WDOG_CYCLES (16)
`endif
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_ssel_active (ssel),
        .i_byte_done   (byte_done),
        .i_byte_rx     (byte_rx),
        .o_byte_tx     (byte_tx),
        .i_status      (status),
        .o_reg_addr    (reg_addr),
        .o_reg_wdata   (reg_wdata),
        .o_reg_we      (reg_we),
        .o_reg_re      (reg_re),
        .i_reg_rdata   (reg_rdata),
        .o_busy        (busy),
        .o_frame_err   (frame_err)
    );

    // Register file model: read data valid the cycle after reg_re
    always @(posedge clk) begin
        if (reg_re) reg_rdata <= mem[reg_addr];
    end

    // Monitor: every strobe must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) ferr_cnt++;
            if (reg_we && reg_re) begin
                n_cmp++;
                n_bad++;
                $display("FAIL strobe_overlap: got we=1 re=1 addr=%h required exclusive", reg_addr);
            end else if (reg_we || reg_re) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_strobe: got we=%0b re=%0b addr=%h data=%h required none",
                             reg_we, reg_re, reg_addr, reg_wdata);
                end else begin
                    txn_t e;
                    e = sb.pop_front();
                    if (e.we != reg_we || e.addr != reg_addr || (reg_we && e.data != reg_wdata)) begin
                        n_bad++;
                        $display("FAIL strobe: got we=%0b addr=%h data=%h required we=%0b addr=%h data=%h",
                                 reg_we, reg_addr, reg_wdata, e.we, e.addr, e.data);
                    end else begin
                        $display("ok   strobe: we=%0b addr=%h data=%h", reg_we, reg_addr,
                                 reg_we ? reg_wdata : 8'h00);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic exp_wr(input logic [6:0] a, input logic [7:0] d);
        sb.push_back('{we: 1'b1, addr: a, data: d});
    endtask

    task automatic exp_rd(input logic [6:0] a);
        sb.push_back('{we: 1'b0, addr: a, data: 8'h00});
    endtask

    task automatic frame_start();
        @(posedge clk); #1;
        ssel = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic frame_end();
        @(posedge clk); #1;
        ssel = 1'b0;
        @(posedge clk); #1;
    endtask

    // Pulse byte_done for one cycle; returns 1ns after the consuming edge
    task automatic send_byte(input logic [7:0] b, input bit drop);
        @(posedge clk); #1;
        byte_rx   = b;
        byte_done = 1'b1;
        if (drop) ssel = 1'b0;
        @(posedge clk); #1;
        byte_done = 1'b0;
    endtask

    initial begin
        int first_err;
        for (int i = 0; i < 128; i++) mem[i] = 8'(i ^ 8'hC3);
        mem[7'h10] = 8'h11;
        mem[7'h11] = 8'h22;
        mem[7'h12] = 8'h33;
        mem[7'h20] = 8'h99;
        mem[7'h30] = 8'h77;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_byte_tx", 32'(byte_tx), 32'h00);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_we_re", 32'({reg_we, reg_re}), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_byte_tx_status", 32'(byte_tx), 32'(STATUS));
        chk("idle_busy", 32'(busy), 32'h0);

        // byte_done with ssel low is ignored
        send_byte(8'h85, 1'b0);
        @(posedge clk); #1;
        chk("ignored_byte_busy", 32'(busy), 32'h0);

        // Write frame 0x85, 0xAA, 0xBB
        frame_start();
        chk("cmd_busy", 32'(busy), 32'h1);
        exp_wr(7'h05, 8'hAA);
        exp_wr(7'h06, 8'hBB);
        send_byte(8'h85, 1'b0);
        send_byte(8'hAA, 1'b0);
        chk("wr_echo_aa", 32'(byte_tx), 32'hAA);
        send_byte(8'hBB, 1'b0);
        chk("wr_echo_bb", 32'(byte_tx), 32'hBB);
        frame_end();
        chk("wr_end_busy", 32'(busy), 32'h0);
        chk("wr_end_byte_tx", 32'(byte_tx), 32'(STATUS));
        chk("wr_sb_empty", 32'(sb.size()), 32'h0);

        // Read frame 0x10 plus two dummy bytes
        frame_start();
        exp_rd(7'h10);
        send_byte(8'h10, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rd_byte0", 32'(byte_tx), 32'h11);
        exp_rd(7'h11);
        send_byte(8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rd_byte1", 32'(byte_tx), 32'h22);
        exp_rd(7'h12);
        send_byte(8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rd_byte2", 32'(byte_tx), 32'h33);
        frame_end();
        chk("rd_sb_empty", 32'(sb.size()), 32'h0);

        // Write from 0xFF wraps the address 0x7F -> 0x00
        frame_start();
        exp_wr(7'h7F, 8'h01);
        exp_wr(7'h00, 8'h02);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        chk("wrap_echo", 32'(byte_tx), 32'h02);
        frame_end();
        chk("wrap_sb_empty", 32'(sb.size()), 32'h0);

        // ssel drops in the byte_done cycle of a write data byte
        frame_start();
        exp_wr(7'h03, 8'h44);
        send_byte(8'h83, 1'b0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h55, 1'b1);
        chk("drop_busy", 32'(busy), 32'h0);
        chk("drop_byte_tx", 32'(byte_tx), 32'(STATUS));
        repeat (3) @(posedge clk);
        #1;
        chk("drop_sb_empty", 32'(sb.size()), 32'h0);

        // Command-only read frame: prefetch completes, data is discarded
        frame_start();
        exp_rd(7'h20);
        send_byte(8'h20, 1'b0);
        ssel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("cmdonly_byte_tx", 32'(byte_tx), 32'(STATUS));
        chk("cmdonly_busy", 32'(busy), 32'h0);
        chk("cmdonly_sb_empty", 32'(sb.size()), 32'h0);

        // Watchdog: command byte then idle
        frame_start();
        send_byte(8'h81, 1'b0);
        first_err = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (frame_err && first_err == 0) first_err = i;
        end
`ifdef SPI_CMD_WDOG_EN
        chk("wdog_err_cycle", 32'(first_err), 32'd16);
        chk("wdog_err_pulses", 32'(ferr_cnt), 32'd1);
        chk("wdog_byte_tx", 32'(byte_tx), 32'hFF);
        chk("wdog_busy", 32'(busy), 32'h1);
        send_byte(8'h12, 1'b0);
        @(posedge clk); #1;
        chk("wdog_ignore_byte", 32'(byte_tx), 32'hFF);
`else
        chk("nowdog_err_cycle", 32'(first_err), 32'd0);
        chk("nowdog_err_pulses", 32'(ferr_cnt), 32'd0);
        chk("nowdog_busy", 32'(busy), 32'h1);
`endif
        frame_end();
        chk("wdog_end_busy", 32'(busy), 32'h0);

        // Reset asserted mid-READ, in the cycle of a byte_done
        frame_start();
        exp_rd(7'h30);
        send_byte(8'h30, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("midrd_byte_tx", 32'(byte_tx), 32'h77);
        byte_rx   = 8'h00;
        byte_done = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        chk("midrd_rst_byte_tx", 32'(byte_tx), 32'h00);
        chk("midrd_rst_busy", 32'(busy), 32'h0);
        chk("midrd_rst_addr", 32'(reg_addr), 32'h00);
        chk("midrd_rst_wdata", 32'(reg_wdata), 32'h00);
        chk("midrd_rst_strobes", 32'({reg_we, reg_re, frame_err}), 32'h0);
        byte_done = 1'b0;
        ssel      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("midrd_after_busy", 32'(busy), 32'h0);
        chk("final_sb_empty", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
